pcpu_regfile: RTL and testbench
===============================

PCPU_REGFILE -- requirements
Module: pcpu_regfile

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning register and data-path width.
REQ-002 SHALL have parameter NREG, default 8, meaning number of general registers.
REQ-003 SHALL have parameter ADDR_W, default 3, meaning register address width; NREG <= 2**ADDR_W.
REQ-004 SHALL have parameter R0_ZERO, default 0, meaning register 0 is hardwired to zero when 1.
REQ-005 SHALL have ports clock (in, 1, sole clock, rising edge) and reset (in, 1, asynchronous, active-low), listed first.
REQ-006 SHALL have port state (in, 1, 1 = CPU executing, 0 = halted).
REQ-007 SHALL have ports ra_addr and rb_addr (in, ADDR_W each, ID-stage source addresses).
REQ-008 SHALL have port id_en (in, 1, ID stage captures operands this cycle).
REQ-009 SHALL have ports ex_we, ex_load (in, 1 each), ex_addr (in, ADDR_W) and ex_data (in, DATA_W); these are the EX-stage result and ALU output.
REQ-010 SHALL have ports mem_we (in, 1), mem_addr (in, ADDR_W) and mem_data (in, DATA_W); these are the MEM-stage result, with load data already selected.
REQ-011 SHALL have ports wb_we (in, 1), wb_addr (in, ADDR_W) and wb_data (in, DATA_W); these form the write-back port.
REQ-012 SHALL have ports reg_A and reg_B (out, DATA_W each, registered operands).
REQ-013 SHALL have port stall (out, 1, load-use interlock, combinational).
REQ-014 SHALL have ports selectGr (in, ADDR_W) and grData (out, DATA_W), forming the combinational board-evaluation read port.
REQ-015 SHALL have port stall_cnt (out, 16, saturating count of stall cycles).

Function
REQ-016 SHALL write wb_data into register wb_addr on a rising edge when state=1 and wb_we=1.
REQ-017 SHALL ignore writes when state=0, when wb_addr>=NREG, or when R0_ZERO=1 and wb_addr=0.
REQ-018 SHALL resolve each source operand by priority: EX match, then MEM match, then WB match (see REQ-030), then the array; a match requires we=1 and equal address.
REQ-019 SHALL treat a source address >=NREG, or address 0 with R0_ZERO=1, as value 0 with no forwarding.
REQ-020 SHALL assert stall when state=1, id_en=1, ex_we=1, ex_load=1 and ex_addr equals a valid source address (ra_addr or rb_addr).
REQ-021 SHALL load reg_A and reg_B with the resolved operands on a rising edge when state=1, id_en=1 and stall=0; otherwise reg_A and reg_B hold.
REQ-022 SHALL give operand latency of exactly one cycle from address presentation to reg_A/reg_B.
REQ-023 SHALL make stall purely combinational; the upstream stage holds its instruction, and the bubble is inserted outside this block.
REQ-024 SHALL increment stall_cnt on each rising edge with stall=1, saturating at 16'hFFFF with no wrap.
REQ-025 SHALL drive grData with the array value at selectGr, bypassing no stage, or 0 when selectGr>=NREG.
REQ-026 SHALL, when state=0, drive stall to 0, hold stall_cnt and hold all registers.

Reset
REQ-027 SHALL, while reset=0, asynchronously clear all NREG registers, reg_A, reg_B and stall_cnt to 0.
REQ-028 SHALL, on a reset asserted mid-stall, clear the registers immediately; stall then reflects only the current inputs.
REQ-029 SHALL leave grData and stall combinational with respect to the cleared state.

Configuration
REQ-030 SHALL, when REGFILE_BYPASS_EN is defined, forward wb_data to a same-cycle read of wb_addr (WB priority in REQ-018).
REQ-031 SHALL, when REGFILE_BYPASS_EN is not defined, return the pre-write array value for a same-cycle read of wb_addr; the WB match term is removed.

Structure
REQ-032 SHALL take default DATA_W, NREG, ADDR_W and the stall counter width constant from shared package pcpu_pkg.
REQ-033 SHALL implement the per-operand priority resolution in sub-module pcpu_fwd_mux, instantiated twice (A and B).

Verification
REQ-034 SHALL be verified with: reset=0 then 1, write r3=16'h1234 via WB, then read ra=3 -> reg_A=16'h1234 one cycle after id_en.
REQ-035 SHALL be verified with: ex_we=1, ex_addr=2, ex_data=16'hAAAA together with mem_we=1, mem_addr=2, mem_data=16'h5555, ra=2 -> reg_A=16'hAAAA.
REQ-036 SHALL be verified with: ex_load=1, ex_addr=5, rb=5, id_en=1 for 3 cycles -> stall=1 each cycle, reg_B held, stall_cnt=3.
REQ-037 SHALL be verified with: wb_we=1, wb_addr=4, wb_data=16'h00FF and ra=4 in the same cycle -> reg_A=16'h00FF with REGFILE_BYPASS_EN defined, and the old value without it.
REQ-038 SHALL be verified with: R0_ZERO=1, write r0=16'hFFFF -> selectGr=0 gives grData=0, and ra=0 gives reg_A=0.
REQ-039 SHALL be verified with: state=0 with wb_we=1 to r1 -> r1 unchanged, and stall=0 regardless of a load match.

Source files
------------

// File: rtl/pcpu_pkg.sv
// Shared constants for the pipelined CPU register file: default widths,
// register count and the stall counter width, plus a saturating increment.
// Latency: n/a (package only). Backpressure: n/a.
package pcpu_pkg;

   localparam int PCPU_DATA_W  = 16;
   localparam int PCPU_NREG    = 8;
   localparam int PCPU_ADDR_W  = 3;
   localparam int STALL_CNT_W  = 16;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/pcpu_fwd_mux.sv
// Per-operand source resolution: EX, then MEM, then (optionally) WB, then array.
// Latency: combinational. Backpressure: none; the caller handles load-use stalls.
// Ports: src_ok/src_addr select the operand, *_we/*_addr/*_data are the stage
// results, arr_data is the array read, fwd_data the resolved operand.
// Macro REGFILE_BYPASS_EN adds the WB-stage forwarding term and its ports.
module pcpu_fwd_mux #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
) (
   input  logic              src_ok,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [DATA_W-1:0] arr_data,
   input  logic              ex_we,
   input  logic [ADDR_W-1:0] ex_addr,
   input  logic [DATA_W-1:0] ex_data,
   input  logic              mem_we,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_data,
`ifdef REGFILE_BYPASS_EN
   input  logic              wb_we,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
`endif
   output logic [DATA_W-1:0] fwd_data
);

   always_comb begin
      fwd_data = arr_data;
      // Invalid or hardwired-zero sources never pick up a forwarded value.
      if (!src_ok) begin
         fwd_data = '0;
      end else if (ex_we && (ex_addr == src_addr)) begin
         fwd_data = ex_data;
      end else if (mem_we && (mem_addr == src_addr)) begin
         fwd_data = mem_data;
`ifdef REGFILE_BYPASS_EN
      end else if (wb_we && (wb_addr == src_addr)) begin
         fwd_data = wb_data;
`endif
      end
   end

endmodule

// File: rtl/pcpu_regfile.sv
// Register file with EX/MEM(/WB) operand forwarding, load-use stall and board read port.
// Latency: one cycle from ra_addr/rb_addr to reg_A/reg_B; grData and stall combinational.
// Backpressure: stall asks upstream to hold its instruction; operands hold while stalled.
// Ports: clock/reset (async, active-low); state gates all activity; ra/rb/id_en
// are ID-stage reads; ex_*, mem_*, wb_* are stage results; selectGr/grData is the
// debug read port; stall_cnt counts stalled cycles, saturating.
// Macro REGFILE_BYPASS_EN: forward wb_data to a same-cycle read of wb_addr.
module pcpu_regfile
   import pcpu_pkg::*;
#(
   parameter int DATA_W  = PCPU_DATA_W,
   parameter int NREG    = PCPU_NREG,
   parameter int ADDR_W  = PCPU_ADDR_W,
   parameter int R0_ZERO = 0
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   state,
   input  logic [ADDR_W-1:0]      ra_addr,
   input  logic [ADDR_W-1:0]      rb_addr,
   input  logic                   id_en,
   input  logic                   ex_we,
   input  logic                   ex_load,
   input  logic [ADDR_W-1:0]      ex_addr,
   input  logic [DATA_W-1:0]      ex_data,
   input  logic                   mem_we,
   input  logic [ADDR_W-1:0]      mem_addr,
   input  logic [DATA_W-1:0]      mem_data,
   input  logic                   wb_we,
   input  logic [ADDR_W-1:0]      wb_addr,
   input  logic [DATA_W-1:0]      wb_data,
   output logic [DATA_W-1:0]      reg_A,
   output logic [DATA_W-1:0]      reg_B,
   output logic                   stall,
   input  logic [ADDR_W-1:0]      selectGr,
   output logic [DATA_W-1:0]      grData,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   logic [DATA_W-1:0] regs [NREG];
   logic [DATA_W-1:0] arr_a, arr_b, fwd_a, fwd_b;
   logic              ra_ok, rb_ok, op_load;

   // A source is real only if it names an implemented, writable register.
   function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
      return (int'(a) < NREG) && !((R0_ZERO != 0) && (a == '0));
   endfunction

   assign ra_ok = addr_ok(ra_addr);
   assign rb_ok = addr_ok(rb_addr);

   // Array reads by compare-and-select so out-of-range addresses read 0
   // without indexing past the array.
   always_comb begin
      arr_a  = '0;
      arr_b  = '0;
      grData = '0;
      for (int i = 0; i < NREG; i++) begin
         if (ADDR_W'(i) == ra_addr)  arr_a  = regs[i];
         if (ADDR_W'(i) == rb_addr)  arr_b  = regs[i];
         if (ADDR_W'(i) == selectGr) grData = regs[i];
      end
   end

   // Load result is not available until MEM, so a dependent ID read must wait.
   assign stall = state && id_en && ex_we && ex_load &&
                  ((ra_ok && (ex_addr == ra_addr)) || (rb_ok && (ex_addr == rb_addr)));

   assign op_load = state && id_en && !stall;

   pcpu_fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd_a (
      .src_ok   (ra_ok),
      .src_addr (ra_addr),
      .arr_data (arr_a),
      .ex_we    (ex_we),
      .ex_addr  (ex_addr),
      .ex_data  (ex_data),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_data (mem_data),
`ifdef REGFILE_BYPASS_EN
      .wb_we    (wb_we),
      .wb_addr  (wb_addr),
      .wb_data  (wb_data),
`endif
      .fwd_data (fwd_a)
   );

   pcpu_fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd_b (
      .src_ok   (rb_ok),
      .src_addr (rb_addr),
      .arr_data (arr_b),
      .ex_we    (ex_we),
      .ex_addr  (ex_addr),
      .ex_data  (ex_data),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_data (mem_data),
`ifdef REGFILE_BYPASS_EN
      .wb_we    (wb_we),
      .wb_addr  (wb_addr),
      .wb_data  (wb_data),
`endif
      .fwd_data (fwd_b)
   );

   // Register array: write-back port; register 0 is read-only when hardwired.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (state && wb_we) begin
         for (int i = 0; i < NREG; i++) begin
            if ((ADDR_W'(i) == wb_addr) && !((R0_ZERO != 0) && (i == 0)))
               regs[i] <= wb_data;
         end
      end
   end

   // Operand registers and stall counter.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         reg_A     <= '0;
         reg_B     <= '0;
         stall_cnt <= '0;
      end else begin
         if (op_load) begin
            reg_A <= fwd_a;
            reg_B <= fwd_b;
         end
         // stall is already forced low when halted, so the count holds then.
         if (stall) stall_cnt <= sat_inc(stall_cnt);
      end
   end

endmodule

// File: tb/tb_pcpu_regfile.sv
// Directed self-checking bench for pcpu_regfile (plus an R0_ZERO=1 instance).
// Latency: n/a. Backpressure: n/a.
module tb_pcpu_regfile;

   logic        clock = 1'b0;
   logic        reset;
   logic        state;
   logic [2:0]  ra_addr, rb_addr, ex_addr, mem_addr, wb_addr, selectGr;
   logic        id_en, ex_we, ex_load, mem_we, wb_we;
   logic [15:0] ex_data, mem_data, wb_data;
   logic [15:0] reg_A, reg_B, grData, stall_cnt;
   logic        stall;
   logic [15:0] reg_A_z, reg_B_z, grData_z, stall_cnt_z;
   logic        stall_z;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   pcpu_regfile dut (
      .clock(clock), .reset(reset), .state(state),
      .ra_addr(ra_addr), .rb_addr(rb_addr), .id_en(id_en),
      .ex_we(ex_we), .ex_load(ex_load), .ex_addr(ex_addr), .ex_data(ex_data),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
      .reg_A(reg_A), .reg_B(reg_B), .stall(stall),
      .selectGr(selectGr), .grData(grData), .stall_cnt(stall_cnt)
   );

   pcpu_regfile #(.R0_ZERO(1)) dut_z (
      .clock(clock), .reset(reset), .state(state),
      .ra_addr(ra_addr), .rb_addr(rb_addr), .id_en(id_en),
      .ex_we(ex_we), .ex_load(ex_load), .ex_addr(ex_addr), .ex_data(ex_data),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
      .reg_A(reg_A_z), .reg_B(reg_B_z), .stall(stall_z),
      .selectGr(selectGr), .grData(grData_z), .stall_cnt(stall_cnt_z)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b0; state = 1'b0;
      ra_addr = 3'd0; rb_addr = 3'd0; id_en = 1'b0;
      ex_we = 1'b0; ex_load = 1'b0; ex_addr = 3'd0; ex_data = 16'h0;
      mem_we = 1'b0; mem_addr = 3'd0; mem_data = 16'h0;
      wb_we = 1'b0; wb_addr = 3'd0; wb_data = 16'h0;
      selectGr = 3'd3;
      #2;
      chk("rst_reg_A", reg_A, 16'h0);
      chk("rst_reg_B", reg_B, 16'h0);
      chk("rst_stall_cnt", stall_cnt, 16'h0);
      chk("rst_grData", grData, 16'h0);
      chk("rst_stall", {15'h0, stall}, 16'h0);

      @(negedge clock);
      reset = 1'b1;
      state = 1'b1;

      // Write r3 through WB, then read it.
      wb_we = 1'b1; wb_addr = 3'd3; wb_data = 16'h1234;
      tick();
      wb_we = 1'b0; ra_addr = 3'd3; rb_addr = 3'd0; id_en = 1'b1;
      #1;
      chk("gr_r3", grData, 16'h1234);
      tick();
      chk("rd_r3_A", reg_A, 16'h1234);
      chk("rd_r0_B", reg_B, 16'h0);
      id_en = 1'b0;

      // r2 in the array, then EX beats MEM beats array.
      wb_we = 1'b1; wb_addr = 3'd2; wb_data = 16'h0BEE;
      tick();
      wb_we = 1'b0;
      ra_addr = 3'd2; rb_addr = 3'd3; id_en = 1'b1;
      ex_we = 1'b1; ex_addr = 3'd2; ex_data = 16'hAAAA;
      mem_we = 1'b1; mem_addr = 3'd2; mem_data = 16'h5555;
      tick();
      chk("ex_over_mem_A", reg_A, 16'hAAAA);
      chk("arr_B", reg_B, 16'h1234);
      ex_we = 1'b0;
      tick();
      chk("mem_over_arr_A", reg_A, 16'h5555);
      mem_we = 1'b0;
      tick();
      chk("arr_r2_A", reg_A, 16'h0BEE);

      // Load-use stall for three cycles.
      ra_addr = 3'd3; rb_addr = 3'd5;
      ex_we = 1'b1; ex_load = 1'b1; ex_addr = 3'd5; ex_data = 16'h7777;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall_on", {15'h0, stall}, 16'h1);
         tick();
         chk("stall_hold_B", reg_B, 16'h1234);
         chk("stall_hold_A", reg_A, 16'h0BEE);
      end
      chk("stall_cnt_3", stall_cnt, 16'd3);
      ex_load = 1'b0;
      #1;
      chk("stall_off", {15'h0, stall}, 16'h0);
      tick();
      chk("post_stall_B", reg_B, 16'h7777);
      chk("post_stall_A", reg_A, 16'h1234);
      chk("stall_cnt_hold", stall_cnt, 16'd3);
      ex_we = 1'b0;

      // Same-cycle WB read of r4.
      wb_we = 1'b1; wb_addr = 3'd4; wb_data = 16'h0042; id_en = 1'b0;
      tick();
      wb_data = 16'h00FF; ra_addr = 3'd4; id_en = 1'b1;
      tick();
`ifdef REGFILE_BYPASS_EN
      chk("wb_same_cycle", reg_A, 16'h00FF);
`else
      chk("wb_same_cycle", reg_A, 16'h0042);
`endif
      wb_we = 1'b0;
      tick();
      chk("wb_after", reg_A, 16'h00FF);

      // Register 0: writable normally, hardwired zero with R0_ZERO=1.
      id_en = 1'b0;
      wb_we = 1'b1; wb_addr = 3'd0; wb_data = 16'hFFFF;
      tick();
      wb_we = 1'b0; selectGr = 3'd0;
      #1;
      chk("r0z_grData", grData_z, 16'h0);
      chk("r0_grData", grData, 16'hFFFF);
      ra_addr = 3'd0; id_en = 1'b1;
      ex_we = 1'b1; ex_addr = 3'd0; ex_data = 16'h1111;
      tick();
      chk("r0_ex_fwd", reg_A, 16'h1111);
      chk("r0z_no_fwd", reg_A_z, 16'h0);
      ex_we = 1'b0;
      tick();
      chk("r0_arr", reg_A, 16'hFFFF);
      chk("r0z_arr", reg_A_z, 16'h0);

      // Halted: no write, no stall, everything holds.
      state = 1'b0;
      wb_we = 1'b1; wb_addr = 3'd1; wb_data = 16'hBEEF;
      ex_we = 1'b1; ex_load = 1'b1; ex_addr = 3'd1; ra_addr = 3'd1; id_en = 1'b1;
      #1;
      chk("halt_stall", {15'h0, stall}, 16'h0);
      tick();
      state = 1'b1; wb_we = 1'b0; ex_we = 1'b0; ex_load = 1'b0; id_en = 1'b0;
      selectGr = 3'd1;
      #1;
      chk("halt_no_write", grData, 16'h0);
      chk("halt_hold_A", reg_A, 16'hFFFF);
      chk("halt_stall_cnt", stall_cnt, 16'd3);

      // Reset in the middle of a stall.
      ex_we = 1'b1; ex_load = 1'b1; ex_addr = 3'd5; rb_addr = 3'd5; id_en = 1'b1;
      selectGr = 3'd3;
      #1;
      chk("stall_again", {15'h0, stall}, 16'h1);
      tick();
      chk("stall_cnt_4", stall_cnt, 16'd4);
      #2;
      reset = 1'b0;
      #1;
      chk("arst_stall_cnt", stall_cnt, 16'h0);
      chk("arst_reg_A", reg_A, 16'h0);
      chk("arst_reg_B", reg_B, 16'h0);
      chk("arst_grData", grData, 16'h0);
      chk("arst_stall_comb", {15'h0, stall}, 16'h1);
      reset = 1'b1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
